// File: rtl/tt_um_secb_b15_array_multiplier.sv
// Registered 4x4 unsigned multiplier built from a structural AND/half-adder/full-adder array.
// ui_in[3:0] is A and ui_in[7:4] is B; uo_out holds A*B one enabled clock later.

module HalfAdder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// One ripple-carry row: adds the shifted running sum to the next partial-product row.
module ArrayRow (
  input  logic [3:0] accIn,
  input  logic [3:0] ppIn,
  output logic [3:0] sum,
  output logic       cout
);
  logic c0, c1, c2;

  HalfAdder u_ha0 (.a(accIn[0]), .b(ppIn[0]),            .sum(sum[0]), .cout(c0));
  FullAdder u_fa1 (.a(accIn[1]), .b(ppIn[1]), .cin(c0), .sum(sum[1]), .cout(c1));
  FullAdder u_fa2 (.a(accIn[2]), .b(ppIn[2]), .cin(c1), .sum(sum[2]), .cout(c2));
  FullAdder u_fa3 (.a(accIn[3]), .b(ppIn[3]), .cin(c2), .sum(sum[3]), .cout(cout));
endmodule

module tt_um_secb_b15_array_multiplier (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [3:0] opA, opB;
  logic [3:0] pp0, pp1, pp2, pp3;
  logic [3:0] sum1, sum2, sum3;
  logic       carry1, carry2, carry3;
  logic [7:0] product_d, product_q;
  logic       unused_uio;

  assign opA = ui_in[3:0];
  assign opB = ui_in[7:4];

  // Partial product row j is A gated by bit j of B.
  assign pp0 = opA & {4{opB[0]}};
  assign pp1 = opA & {4{opB[1]}};
  assign pp2 = opA & {4{opB[2]}};
  assign pp3 = opA & {4{opB[3]}};

  // Each row retires its lowest sum bit as a product bit and passes the rest up with its carry.
  ArrayRow u_row1 (.accIn({1'b0,   pp0[3:1]}),  .ppIn(pp1), .sum(sum1), .cout(carry1));
  ArrayRow u_row2 (.accIn({carry1, sum1[3:1]}), .ppIn(pp2), .sum(sum2), .cout(carry2));
  ArrayRow u_row3 (.accIn({carry2, sum2[3:1]}), .ppIn(pp3), .sum(sum3), .cout(carry3));

  assign product_d = {carry3, sum3, sum2[0], sum1[0], pp0[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= 8'h00;
    end else if (ena) begin
      product_q <= product_d;
    end
  end

  assign uo_out     = product_q;
  assign uio_out    = 8'h00;
  assign uio_oe     = 8'h00;
  assign unused_uio = ^uio_in;
endmodule

// File: tb/tb_tt_um_secb_b15_array_multiplier.sv
// Directed and exhaustive bench for the registered 4x4 array multiplier.
// Inputs change 1ns after each rising edge; outputs are checked there too.

module tb_tt_um_secb_b15_array_multiplier;
  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checkCount;
  int passCount;

  tt_um_secb_b15_array_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", tag, observed, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  // Drive one set of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic [7:0] ui, input logic en, input logic [7:0] uio);
    ui_in  = ui;
    ena    = en;
    uio_in = uio;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] expected;
    logic [7:0] heldValue;
    checkCount = 0;
    passCount  = 0;

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'hFF;
    uio_in = 8'hA5;
    #2;
    checkOutput("reset_uo_before_clock", uo_out, 8'h00);
    checkOutput("reset_uio_out", uio_out, 8'h00);
    checkOutput("reset_uio_oe", uio_oe, 8'h00);
    applyStimulus(8'hFF, 1'b1, 8'h5A);
    checkOutput("reset_uo_after_edge", uo_out, 8'h00);
    applyStimulus(8'hFF, 1'b1, 8'h3C);
    checkOutput("reset_uo_after_edge2", uo_out, 8'h00);

    rst_n = 1'b1;
    #2;
    checkOutput("release_no_edge", uo_out, 8'h00);
    applyStimulus(8'hFF, 1'b1, 8'h11);
    checkOutput("max_15x15", uo_out, 8'hE1);
    applyStimulus(8'h3D, 1'b1, 8'h22);
    checkOutput("mixed_13x3", uo_out, 8'h27);
    applyStimulus(8'h70, 1'b1, 8'h33);
    checkOutput("zero_a", uo_out, 8'h00);
    applyStimulus(8'h0A, 1'b1, 8'h44);
    checkOutput("zero_b", uo_out, 8'h00);
    applyStimulus(8'h1F, 1'b1, 8'h55);
    checkOutput("b_is_one", uo_out, 8'h0F);
    applyStimulus(8'h61, 1'b1, 8'h66);
    checkOutput("a_is_one", uo_out, 8'h06);
    applyStimulus(8'hC9, 1'b1, 8'h77);
    checkOutput("mixed_9x12", uo_out, 8'h6C);

    // No combinational path: changing ui_in between edges must not move uo_out.
    ui_in = 8'h00;
    #3;
    checkOutput("no_comb_path", uo_out, 8'h6C);

    for (int i = 0; i < 256; i++) begin
      applyStimulus(8'(i), 1'b1, 8'($urandom_range(0, 255)));
      expected = 8'((i % 16) * (i / 16));
      checkOutput($sformatf("exhaustive_%02h", i), uo_out, expected);
      checkOutput("exhaustive_uio_out", uio_out, 8'h00);
      checkOutput("exhaustive_uio_oe", uio_oe, 8'h00);
    end

    applyStimulus(8'h57, 1'b1, 8'h12);
    checkOutput("hold_load", uo_out, 8'h23);
    heldValue = 8'h23;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'hFF, 1'b0, 8'($urandom_range(0, 255)));
      checkOutput($sformatf("hold_edge_%0d", k), uo_out, heldValue);
    end

    applyStimulus(8'hFF, 1'b1, 8'h9E);
    checkOutput("pre_reset_max", uo_out, 8'hE1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_uo", uo_out, 8'h00);
    checkOutput("async_reset_uio_out", uio_out, 8'h00);
    checkOutput("async_reset_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    ui_in = 8'h22;
    #1;
    checkOutput("after_release_no_edge", uo_out, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("first_edge_after_reset", uo_out, 8'h04);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
